sonar_adc_capture: RTL
======================

Name: sonar_adc_capture

Overview:
- Drives one serial-output 14-bit hydrophone ADC channel: issues the conversion strobe, generates the serial clock, and deserializes SDO MSB-first into a 14-bit word.
- Presents each completed word on a valid/ready interface to the downstream sample buffer/filter stage.
- Sits directly downstream of the ADC pins and upstream of per-channel sample storage.

Parameters:
- DATA_W, 14, bits per ADC sample.
- SCK_DIV, 2, clk cycles per SCK half-period; legal range ≥1.
- CONV_CYCLES, 8, clk cycles adc_cnv is held high per conversion; legal range ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; while high, conversions repeat back-to-back.
- adc_sdo  in  1  ADC serial data, MSB first; pre-synchronized externally.
- adc_cnv  out  1  conversion strobe to ADC.
- adc_sck  out  1  serial clock to ADC.
- sample_data  out  DATA_W  captured word.
- sample_valid  out  1  sample_data holds an unconsumed word.
- sample_ready  in  1  downstream accepts word when high with sample_valid.
- overrun_clr  in  1  synchronous clear of overrun.
- overrun  out  1  sticky flag: a word was dropped.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state, including mid-frame):
  - State goes to IDLE.
  - adc_cnv=0, adc_sck=0, sample_data=0, sample_valid=0, overrun=0, busy=0.
  - Bit counter, divider counter and shift register cleared.
- States:
  - IDLE: if run=1 -> CONVERT next cycle.
  - CONVERT: adc_cnv=1 for exactly CONV_CYCLES cycles -> ACQ.
  - ACQ: adc_cnv=0. adc_sck toggles every SCK_DIV cycles, starting low. Exactly DATA_W rising edges are generated.
  - LATCH: 1 cycle, transfers the word to the output stage. Then -> CONVERT if run=1, else -> IDLE.
- Sampling:
  - adc_sdo is shifted in (shift left, LSB entry) on the clk edge on which adc_sck is driven 0->1.
  - The first bit shifted is the MSB.
  - adc_sck returns low and stays low after the final high phase, before LATCH.
- run deasserted mid-frame: the current frame completes and is delivered normally; no new CONVERT is started.
- Frame length per sample: CONV_CYCLES + 2*SCK_DIV*DATA_W + 1 cycles. Defaults: 8 + 56 + 1 = 65.
- Latency: sample_valid rises the cycle after LATCH. First word: 1 + 65 cycles after run rises in IDLE.
- Output handshake:
  - A transfer occurs on any cycle with sample_valid & sample_ready; sample_valid falls next cycle unless a new word loads that same cycle.
  - sample_data is stable while sample_valid=1 and not accepted.
  - In LATCH with sample_valid=0, or with sample_valid=1 and sample_ready=1 (simultaneous accept and load): load the new word, sample_valid=1.
  - In LATCH with sample_valid=1 and sample_ready=0: new word dropped, old word kept, overrun set next cycle.
- overrun:
  - Sticky until overrun_clr=1.
  - If clear and set coincide, set wins.
- Width rules: bit counter ceil(log2(DATA_W+1)) bits; divider counter ceil(log2(SCK_DIV)) bits, minimum 1. No wrap is permitted beyond DATA_W edges.

Decomposition:
- Shared package sonar_adc_pkg:
  - state encoding (IDLE, CONVERT, ACQ, LATCH);
  - default DATA_W=14;
  - SCK_DIV and CONV_CYCLES defaults.
- One sub-module, sonar_adc_shift_in: DATA_W-bit serial-in/parallel-out shift register with shift enable and asynchronous active-high clear. Instantiated once; the controller FSM and output stage stay in the top.

Test Plan:
- ADC model returns 14'h2A5C, defaults, run pulsed high for 1 cycle -> single frame; sample_data=14'h2A5C with sample_valid rising 66 cycles after run; adc_cnv high exactly 8 cycles; exactly 14 adc_sck rising edges, each high 2 cycles; then IDLE, busy=0.
- run held high, sample_ready=1, model returns 14'h0001, 14'h3FFF, 14'h2000 -> three words delivered in order, 65 cycles apart; overrun=0.
- run high, sample_ready=0 for 3 frames (words 14'h1111, 14'h2222, 14'h3333) -> sample_data stays 14'h1111; overrun=1 after second LATCH; then overrun_clr pulse -> overrun=0; sample_ready=1 -> 14'h1111 accepted, sample_valid drops.
- sample_ready asserted in the same cycle as LATCH while a word is pending -> old word transferred, new word loaded, sample_valid stays 1, overrun=0.
- reset asserted asynchronously after the 7th adc_sck edge -> adc_sck=0, adc_cnv=0, sample_valid=0 immediately; after release with run=1, the next frame captures a full correct 14-bit word (14'h155A).
- run deasserted during ACQ -> frame finishes, word delivered, no further adc_cnv pulse.

Source files
------------

// File: rtl/sonar_adc_pkg.sv
// sonar_adc_pkg: shared defaults and FSM encoding for the sonar ADC capture block
package sonar_adc_pkg;
    localparam int DEF_DATA_W      = 14;
    localparam int DEF_SCK_DIV     = 2;
    localparam int DEF_CONV_CYCLES = 8;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_ACQ     = 2'd2;
    localparam logic [1:0] ST_LATCH   = 2'd3;
endpackage

// File: rtl/sonar_adc_shift_in.sv
// sonar_adc_shift_in: serial-in/parallel-out shift register, MSB arrives first
module sonar_adc_shift_in
    import sonar_adc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic              din,
    output logic [DATA_W-1:0] q
);
    always_ff @(posedge clk or posedge clr)
        if (clr) q <= '0;
        else if (en) q <= {q[DATA_W-2:0], din};
endmodule

// File: rtl/sonar_adc_capture.sv
// sonar_adc_capture: serial ADC conversion/readout controller with valid/ready output stage
module sonar_adc_capture
    import sonar_adc_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SCK_DIV     = DEF_SCK_DIV,
    parameter int CONV_CYCLES = DEF_CONV_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              adc_sdo,
    output logic              adc_cnv,
    output logic              adc_sck,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    input  logic              overrun_clr,
    output logic              overrun,
    output logic              busy
);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int DW = SCK_DIV > 1 ? $clog2(SCK_DIV) : 1;
    localparam int CW = CONV_CYCLES > 1 ? $clog2(CONV_CYCLES) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);
    localparam logic [CW-1:0] CNV_LAST = CW'(CONV_CYCLES - 1);
    localparam logic [BW-1:0] BITS     = BW'(DATA_W);

    logic [1:0]        state, state_nx;
    logic [BW-1:0]     bit_cnt;
    logic [DW-1:0]     div_cnt;
    logic [CW-1:0]     cnv_cnt;
    logic              sck, tick, shift_en, acq_done, cnv_done, load, drop;
    logic [DATA_W-1:0] word;

    // tick marks the clk edge on which sck toggles; a rising toggle also samples sdo
    assign tick     = state == ST_ACQ && div_cnt == DIV_LAST;
    assign shift_en = tick && !sck;
    assign acq_done = tick && sck && bit_cnt == BITS;
    assign cnv_done = state == ST_CONVERT && cnv_cnt == CNV_LAST;
    assign load     = state == ST_LATCH && (!sample_valid || sample_ready);
    assign drop     = state == ST_LATCH && sample_valid && !sample_ready;
    assign adc_cnv  = state == ST_CONVERT;
    assign adc_sck  = sck;
    assign busy     = state != ST_IDLE;

    always_comb
        state_nx = state == ST_IDLE    ? (run ? ST_CONVERT : ST_IDLE) :
                   state == ST_CONVERT ? (cnv_done ? ST_ACQ : ST_CONVERT) :
                   state == ST_ACQ     ? (acq_done ? ST_LATCH : ST_ACQ) :
                                         (run ? ST_CONVERT : ST_IDLE);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            cnv_cnt      <= '0;
            sck          <= 1'b0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_nx;
            cnv_cnt      <= state == ST_CONVERT && !cnv_done ? cnv_cnt + 1'b1 : '0;
            div_cnt      <= state == ST_ACQ && !tick ? div_cnt + 1'b1 : '0;
            sck          <= tick ? !sck : sck;
            bit_cnt      <= state != ST_ACQ ? '0 : shift_en ? bit_cnt + 1'b1 : bit_cnt;
            sample_data  <= load ? word : sample_data;
            sample_valid <= load ? 1'b1 : sample_valid && !sample_ready;
            overrun      <= drop ? 1'b1 : overrun && !overrun_clr;
        end

    sonar_adc_shift_in #(.DATA_W(DATA_W)) u_shift (
        .clk (clk),
        .clr (reset),
        .en  (shift_en),
        .din (adc_sdo),
        .q   (word)
    );
endmodule
